sha256_round_ctrl: RTL and testbench

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_round_ctrl.sv | 112 +++++++++++
 tb/tb_sha256_round_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// Block-level sequencer for a SHA-256 core: accepts 512-bit blocks, pulses
// init/next, steps the round index, then commits the digest update.
module sha256_round_ctrl #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       block_valid,
   output logic       block_ready,
   input  logic       block_first,
   input  logic       block_last,
   output logic       init,
   output logic       next,
   output logic [5:0] round_idx,
   output logic       round_en,
   output logic       digest_update,
   output logic       digest_valid,
   input  logic       digest_ack,
   output logic       busy,
   output logic       seq_err
);

   localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

   state_t     state, state_nxt;
   logic       msg_open, msg_open_nxt;
   logic       last_q, last_nxt;
   logic [5:0] idx_nxt;
   logic       init_nxt, next_nxt, err_nxt;
   logic       accept;

   // block_ready is itself registered, so it also masks the first IDLE cycle after reset
   assign accept = (state == IDLE) && block_ready && block_valid;

   always_comb begin
      state_nxt    = state;
      msg_open_nxt = msg_open;
      last_nxt     = last_q;
      idx_nxt      = '0;
      init_nxt     = 1'b0;
      next_nxt     = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt    = LOAD;
               last_nxt     = block_last;
               msg_open_nxt = !block_last;
               init_nxt     = block_first || !msg_open;
               next_nxt     = !(block_first || !msg_open);
               // a restart mid-message or a continuation with nothing open both force init
               err_nxt      = (block_first && msg_open) || (!block_first && !msg_open);
            end
         end
         LOAD: begin
            state_nxt = ROUND;
         end
         ROUND: begin
            if (round_idx == LAST_IDX) begin
               state_nxt = UPDATE;
            end else begin
               idx_nxt = round_idx + 6'd1;
            end
         end
         UPDATE: begin
            state_nxt = last_q ? DONE : IDLE;
         end
         DONE: begin
            if (digest_ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // All outputs are decoded from the next state so they come straight from flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         msg_open      <= 1'b0;
         last_q        <= 1'b0;
         round_idx     <= '0;
         block_ready   <= 1'b0;
         busy          <= 1'b0;
         round_en      <= 1'b0;
         digest_update <= 1'b0;
         digest_valid  <= 1'b0;
         init          <= 1'b0;
         next          <= 1'b0;
         seq_err       <= 1'b0;
      end else begin
         state         <= state_nxt;
         msg_open      <= msg_open_nxt;
         last_q        <= last_nxt;
         round_idx     <= idx_nxt;
         block_ready   <= (state_nxt == IDLE);
         busy          <= (state_nxt != IDLE);
         round_en      <= (state_nxt == ROUND);
         digest_update <= (state_nxt == UPDATE);
         digest_valid  <= (state_nxt == DONE);
         init          <= init_nxt;
         next          <= next_nxt;
         seq_err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: a 64-round instance for the protocol
// scenarios and a 17-round instance for the short-round configuration.
module tb_sha256_round_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       block_valid = 1'b0, block_first = 1'b0, block_last = 1'b0, digest_ack = 1'b0;
   logic       block_ready, init, next, round_en, digest_update, digest_valid, busy, seq_err;
   logic [5:0] round_idx;

   logic       block_valid_s = 1'b0, block_first_s = 1'b0, block_last_s = 1'b0, digest_ack_s = 1'b0;
   logic       block_ready_s, init_s, next_s, round_en_s, digest_update_s, digest_valid_s, busy_s, seq_err_s;
   logic [5:0] round_idx_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sha256_round_ctrl #(.NUM_ROUNDS(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .block_valid(block_valid), .block_ready(block_ready),
      .block_first(block_first), .block_last(block_last),
      .init(init), .next(next), .round_idx(round_idx), .round_en(round_en),
      .digest_update(digest_update), .digest_valid(digest_valid),
      .digest_ack(digest_ack), .busy(busy), .seq_err(seq_err)
   );

   sha256_round_ctrl #(.NUM_ROUNDS(17)) dut17 (
      .clk(clk), .reset_n(reset_n),
      .block_valid(block_valid_s), .block_ready(block_ready_s),
      .block_first(block_first_s), .block_last(block_last_s),
      .init(init_s), .next(next_s), .round_idx(round_idx_s), .round_en(round_en_s),
      .digest_update(digest_update_s), .digest_valid(digest_valid_s),
      .digest_ack(digest_ack_s), .busy(busy_s), .seq_err(seq_err_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 200 && !block_ready; k++) tick();
      if (!block_ready) begin
         checks++; errors++;
         $display("FAIL wait_ready: block_ready=%0d after 200 cycles, required 1", block_ready);
      end
   endtask

   // Sends one block and runs to cycle T+66 (the UPDATE cycle), collecting pulses.
   task automatic run_block(input bit first, input bit last,
                            output bit got_init, output bit got_next, output bit got_err,
                            output int upd_cnt, output bit dv_early);
      wait_ready();
      block_valid = 1'b1; block_first = first; block_last = last;
      tick();
      block_valid = 1'b0; block_first = 1'b0; block_last = 1'b0;
      got_init = init; got_next = next; got_err = seq_err;
      upd_cnt = 0; dv_early = 1'b0;
      repeat (65) begin
         tick();
         if (digest_update) upd_cnt++;
         if (digest_valid) dv_early = 1'b1;
         if (seq_err) got_err = 1'b1;
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({init, next, round_idx, round_en, digest_update, digest_valid, busy, block_ready, seq_err} !== 14'd0) begin
         errors++; $display("FAIL reset_outputs: got %b required all zero",
            {init, next, round_idx, round_en, digest_update, digest_valid, busy, block_ready, seq_err});
      end
      tick(); tick();
      reset_n = 1'b1;
      checks++;
      if (block_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %0d required 0", block_ready); end
      tick();
      checks++;
      if (block_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %0d required 1", block_ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %0d required 0", busy); end
   endtask

   task automatic test_single();
      int bad_rounds;
      wait_ready();
      block_valid = 1'b1; block_first = 1'b1; block_last = 1'b1;
      tick();
      block_valid = 1'b0; block_first = 1'b0; block_last = 1'b0;
      checks++;
      if ({init, next, seq_err, round_en, busy, block_ready} !== 6'b100010) begin
         errors++; $display("FAIL single_load: got init,next,err,en,busy,rdy=%b required 100010",
            {init, next, seq_err, round_en, busy, block_ready});
      end
      checks++;
      if (round_idx !== 6'd0) begin errors++; $display("FAIL single_load_idx: got %0d required 0", round_idx); end
      bad_rounds = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (round_en !== 1'b1 || round_idx !== 6'(i) || init !== 1'b0) begin
            bad_rounds++;
            $display("FAIL single_round: cycle %0d got en=%0d idx=%0d required en=1 idx=%0d", i, round_en, round_idx, i);
         end
      end
      checks++;
      if (bad_rounds !== 0) begin errors++; $display("FAIL single_rounds: got %0d bad cycles required 0", bad_rounds); end
      tick();
      checks++;
      if ({digest_update, round_en, round_idx} !== 8'b10_000000) begin
         errors++; $display("FAIL single_update: got upd=%0d en=%0d idx=%0d required 1 0 0", digest_update, round_en, round_idx);
      end
      tick();
      checks++;
      if ({digest_valid, block_ready, digest_update} !== 3'b100) begin
         errors++; $display("FAIL single_done: got dv,rdy,upd=%b required 100", {digest_valid, block_ready, digest_update});
      end
      tick(); tick();
      checks++;
      if (digest_valid !== 1'b1) begin errors++; $display("FAIL single_dv_hold: got %0d required 1", digest_valid); end
      digest_ack = 1'b1;
      tick();
      digest_ack = 1'b0;
      checks++;
      if ({digest_valid, block_ready, busy} !== 3'b010) begin
         errors++; $display("FAIL single_ack: got dv,rdy,busy=%b required 010", {digest_valid, block_ready, busy});
      end
   endtask

   task automatic test_multi();
      bit gi, gn, ge, dv; int up;
      int upd_total; bit err_any; bit [2:0] order;
      upd_total = 0; err_any = 0;
      run_block(1'b1, 1'b0, gi, gn, ge, up, dv);
      order[2] = gi && !gn; upd_total += up; err_any |= ge;
      tick();
      checks++;
      if ({digest_valid, block_ready, dv} !== 3'b010) begin
         errors++; $display("FAIL multi_b1_end: got dv,rdy,early=%b required 010", {digest_valid, block_ready, dv});
      end
      run_block(1'b0, 1'b0, gi, gn, ge, up, dv);
      order[1] = gn && !gi; upd_total += up; err_any |= ge;
      tick();
      checks++;
      if ({digest_valid, block_ready, dv} !== 3'b010) begin
         errors++; $display("FAIL multi_b2_end: got dv,rdy,early=%b required 010", {digest_valid, block_ready, dv});
      end
      run_block(1'b0, 1'b1, gi, gn, ge, up, dv);
      order[0] = gn && !gi; upd_total += up; err_any |= ge;
      tick();
      checks++;
      if ({digest_valid, block_ready, dv} !== 3'b100) begin
         errors++; $display("FAIL multi_b3_end: got dv,rdy,early=%b required 100", {digest_valid, block_ready, dv});
      end
      checks++;
      if (order !== 3'b111) begin errors++; $display("FAIL multi_order: got init/next/next ok=%b required 111", order); end
      checks++;
      if (upd_total !== 3) begin errors++; $display("FAIL multi_updates: got %0d required 3", upd_total); end
      checks++;
      if (err_any !== 1'b0) begin errors++; $display("FAIL multi_seq_err: got %0d required 0", err_any); end
      digest_ack = 1'b1; tick(); digest_ack = 1'b0;
   endtask

   task automatic test_proto_err();
      bit gi, gn, ge, dv; int up;
      run_block(1'b0, 1'b1, gi, gn, ge, up, dv);
      checks++;
      if ({gi, gn, ge} !== 3'b101) begin
         errors++; $display("FAIL err_no_open: got init,next,err=%b required 101", {gi, gn, ge});
      end
      tick();
      checks++;
      if (digest_valid !== 1'b1) begin errors++; $display("FAIL err_no_open_done: got %0d required 1", digest_valid); end
      digest_ack = 1'b1; tick(); digest_ack = 1'b0;
      run_block(1'b1, 1'b0, gi, gn, ge, up, dv);
      checks++;
      if ({gi, gn, ge} !== 3'b100) begin
         errors++; $display("FAIL err_open_first: got init,next,err=%b required 100", {gi, gn, ge});
      end
      tick();
      run_block(1'b1, 1'b0, gi, gn, ge, up, dv);
      checks++;
      if ({gi, gn, ge} !== 3'b101) begin
         errors++; $display("FAIL err_restart: got init,next,err=%b required 101", {gi, gn, ge});
      end
      tick();
      run_block(1'b0, 1'b1, gi, gn, ge, up, dv);
      checks++;
      if ({gi, gn, ge} !== 3'b010) begin
         errors++; $display("FAIL err_after_restart: got init,next,err=%b required 010", {gi, gn, ge});
      end
      tick();
      digest_ack = 1'b1; tick(); digest_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      int ready_hi;
      wait_ready();
      block_valid = 1'b1; block_first = 1'b1; block_last = 1'b1;
      tick();
      ready_hi = 0;
      if (block_ready) ready_hi++;
      repeat (65) begin
         tick();
         if (block_ready) ready_hi++;
      end
      checks++;
      if (ready_hi !== 0) begin errors++; $display("FAIL hold_ready_busy: got %0d ready cycles required 0", ready_hi); end
      tick(); tick();
      checks++;
      if ({digest_valid, block_ready} !== 2'b10) begin
         errors++; $display("FAIL hold_done: got dv,rdy=%b required 10", {digest_valid, block_ready});
      end
      digest_ack = 1'b1;
      tick();
      digest_ack = 1'b0;
      checks++;
      if ({digest_valid, block_ready, init, busy} !== 4'b0100) begin
         errors++; $display("FAIL hold_ack_coincident: got dv,rdy,init,busy=%b required 0100",
            {digest_valid, block_ready, init, busy});
      end
      tick();
      block_valid = 1'b0; block_first = 1'b0; block_last = 1'b0;
      checks++;
      if ({init, block_ready} !== 2'b10) begin
         errors++; $display("FAIL hold_accept_idle: got init,rdy=%b required 10", {init, block_ready});
      end
      repeat (66) tick();
      digest_ack = 1'b1; tick(); digest_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit gi, gn, ge, dv; int up; int stray;
      wait_ready();
      block_valid = 1'b1; block_first = 1'b1; block_last = 1'b0;
      tick();
      block_valid = 1'b0; block_first = 1'b0;
      for (int k = 0; k < 100 && !(round_en && round_idx == 6'd30); k++) tick();
      checks++;
      if (round_idx !== 6'd30) begin errors++; $display("FAIL mid_reach30: got %0d required 30", round_idx); end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({init, next, round_idx, round_en, digest_update, digest_valid, busy, block_ready, seq_err} !== 14'd0) begin
         errors++; $display("FAIL mid_reset_outputs: got %b required all zero",
            {init, next, round_idx, round_en, digest_update, digest_valid, busy, block_ready, seq_err});
      end
      tick();
      reset_n = 1'b1;
      checks++;
      if (block_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_early: got %0d required 0", block_ready); end
      tick();
      checks++;
      if (block_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_release: got %0d required 1", block_ready); end
      stray = 0;
      repeat (80) begin
         tick();
         if (init || next || digest_update || busy) stray++;
      end
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL mid_stray_pulses: got %0d required 0", stray); end
      run_block(1'b0, 1'b1, gi, gn, ge, up, dv);
      checks++;
      if ({gi, gn, ge} !== 3'b101) begin
         errors++; $display("FAIL mid_msg_abandoned: got init,next,err=%b required 101", {gi, gn, ge});
      end
      tick();
      digest_ack = 1'b1; tick(); digest_ack = 1'b0;
   endtask

   task automatic test_rounds17();
      int bad_rounds;
      for (int k = 0; k < 200 && !block_ready_s; k++) tick();
      block_valid_s = 1'b1; block_first_s = 1'b1; block_last_s = 1'b1;
      tick();
      block_valid_s = 1'b0; block_first_s = 1'b0; block_last_s = 1'b0;
      checks++;
      if ({init_s, next_s, seq_err_s} !== 3'b100) begin
         errors++; $display("FAIL r17_load: got init,next,err=%b required 100", {init_s, next_s, seq_err_s});
      end
      bad_rounds = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (round_en_s !== 1'b1 || round_idx_s !== 6'(i)) begin
            bad_rounds++;
            $display("FAIL r17_round: cycle %0d got en=%0d idx=%0d required en=1 idx=%0d", i, round_en_s, round_idx_s, i);
         end
      end
      checks++;
      if (bad_rounds !== 0) begin errors++; $display("FAIL r17_rounds: got %0d bad cycles required 0", bad_rounds); end
      tick();
      checks++;
      if ({digest_update_s, round_en_s, round_idx_s} !== 8'b10_000000) begin
         errors++; $display("FAIL r17_update: got upd=%0d en=%0d idx=%0d required 1 0 0", digest_update_s, round_en_s, round_idx_s);
      end
      tick();
      checks++;
      if (digest_valid_s !== 1'b1) begin errors++; $display("FAIL r17_done: got %0d required 1", digest_valid_s); end
      digest_ack_s = 1'b1; tick(); digest_ack_s = 1'b0;
      checks++;
      if (block_ready_s !== 1'b1) begin errors++; $display("FAIL r17_ack: got %0d required 1", block_ready_s); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_proto_err();
      test_back_to_back();
      test_reset_mid();
      test_rounds17();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
